extmem_arbiter: RTL and testbench

EXTMEM_ARBITER -- requirements
Module: extmem_arbiter

---
 rtl/extmem_arbiter_if.sv | 43 ++++
 rtl/extmem_arbiter.sv | 123 ++++++++++++
 tb/tb_extmem_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/extmem_arbiter_if.sv
// +----------------------------------------------------------------------+
// | extmem_arbiter_if : requester handshakes and external RAM bus        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface extmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          hold;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] dq_out;
    logic          dq_oe;
    logic [DW-1:0] dq_in;
    logic          ce_n;
    logic          wr_n;
    logic          oe_n;
    logic          busy;

    modport master (
        output hold, wr_req, wr_addr, wr_data, rd_req, rd_addr, dq_in,
        input  wr_ack, rd_ack, rd_data, rd_valid, addr, dq_out, dq_oe,
        input  ce_n, wr_n, oe_n, busy
    );

    modport slave (
        input  hold, wr_req, wr_addr, wr_data, rd_req, rd_addr, dq_in,
        output wr_ack, rd_ack, rd_data, rd_valid, addr, dq_out, dq_oe,
        output ce_n, wr_n, oe_n, busy
    );
endinterface

`default_nettype wire

// File: rtl/extmem_arbiter.sv
// +----------------------------------------------------------------------+
// | extmem_arbiter : round-robin write/read arbiter for an async SRAM    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module extmem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  wire logic          clk_out,
    input  wire logic          reset,
    extmem_arbiter_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR1  = 3'd1,
        WR2  = 3'd2,
        RD1  = 3'd3,
        RD2  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic          w_grant_wr;
    logic          w_grant_rd;
    logic          r_last_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_dq_out;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          r_wr_ack;
    logic          r_rd_ack;
    logic          r_ce_n;
    logic          r_wr_n;
    logic          r_oe_n;
    logic          r_dq_oe;
    logic          r_busy;

    // IDLE and the second cycle of an access are the only arbitration points;
    // a tie goes to whichever side was not granted last.
    always_comb begin
        w_state_nx = r_state;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        case (r_state)
            WR1: w_state_nx = WR2;
            RD1: w_state_nx = RD2;
            default: begin
                if (!bus.hold && bus.wr_req && (!bus.rd_req || !r_last_wr)) begin
                    w_grant_wr = 1'b1;
                    w_state_nx = WR1;
                end else if (!bus.hold && bus.rd_req) begin
                    w_grant_rd = 1'b1;
                    w_state_nx = RD1;
                end else begin
                    w_state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Strobes are decoded from the next state so every output comes from a flop.
    always_ff @(posedge clk_out) begin
        if (reset) begin
            r_last_wr  <= 1'b0;
            r_addr     <= '0;
            r_dq_out   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_ce_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_dq_oe    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_wr_ack   <= w_grant_wr;
            r_rd_ack   <= w_grant_rd;
            r_busy     <= (w_state_nx != IDLE);
            r_ce_n     <= (w_state_nx == IDLE);
            r_wr_n     <= (w_state_nx != WR2);
            r_oe_n     <= !((w_state_nx == RD1) || (w_state_nx == RD2));
            r_dq_oe    <= (w_state_nx == WR1) || (w_state_nx == WR2);
            r_rd_valid <= (r_state == RD2);
            if (r_state == RD2) begin
                r_rd_data <= bus.dq_in;
            end
            if (w_grant_wr) begin
                r_last_wr <= 1'b1;
                r_addr    <= bus.wr_addr;
                r_dq_out  <= bus.wr_data;
            end else if (w_grant_rd) begin
                r_last_wr <= 1'b0;
                r_addr    <= bus.rd_addr;
            end
        end
    end

    assign bus.wr_ack   = r_wr_ack;
    assign bus.rd_ack   = r_rd_ack;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.addr     = r_addr;
    assign bus.dq_out   = r_dq_out;
    assign bus.dq_oe    = r_dq_oe;
    assign bus.ce_n     = r_ce_n;
    assign bus.wr_n     = r_wr_n;
    assign bus.oe_n     = r_oe_n;
    assign bus.busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_extmem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_extmem_arbiter : directed and random checks against a phase model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_extmem_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    extmem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    extmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_out (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: m_pos is the cycle index within the current access (0 = none).
    int            m_pos;
    bit            m_wr;
    bit            m_last_wr;
    bit            m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] m_rdata;
    bit            keep_wr;
    bit            keep_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_pos = 0; m_wr = 1'b0; m_last_wr = 1'b0; m_valid = 1'b0;
            m_addr = '0; m_dout = '0; m_rdata = '0;
        end else begin
            m_valid = (m_pos == 2) && !m_wr;
            if (m_valid) m_rdata = bus.dq_in;
            if (m_pos == 1) begin
                m_pos = 2;
            end else if (!bus.hold && (bus.wr_req || bus.rd_req)) begin
                m_wr      = bus.wr_req && (!bus.rd_req || !m_last_wr);
                m_last_wr = m_wr;
                m_pos     = 1;
                if (m_wr) begin
                    m_addr = bus.wr_addr;
                    m_dout = bus.wr_data;
                end else begin
                    m_addr = bus.rd_addr;
                end
            end else begin
                m_pos = 0;
            end
        end
    endtask

    task automatic compare();
        check_eq("busy",     32'(bus.busy),     32'(m_pos != 0));
        check_eq("ce_n",     32'(bus.ce_n),     32'(m_pos == 0));
        check_eq("wr_ack",   32'(bus.wr_ack),   32'(m_pos == 1 && m_wr));
        check_eq("rd_ack",   32'(bus.rd_ack),   32'(m_pos == 1 && !m_wr));
        check_eq("wr_n",     32'(bus.wr_n),     32'(!(m_pos == 2 && m_wr)));
        check_eq("oe_n",     32'(bus.oe_n),     32'(!(m_pos != 0 && !m_wr)));
        check_eq("dq_oe",    32'(bus.dq_oe),    32'(m_pos != 0 && m_wr));
        check_eq("addr",     32'(bus.addr),     32'(m_addr));
        check_eq("dq_out",   32'(bus.dq_out),   32'(m_dout));
        check_eq("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        check_eq("rd_data",  32'(bus.rd_data),  32'(m_rdata));
        check_eq("wr_oe_excl", 32'(bus.wr_n | bus.oe_n), 32'd1);
        check_eq("oe_dq_excl", 32'(!(bus.dq_oe && !bus.oe_n)), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        if (m_pos == 1 && m_wr) begin
            if (keep_wr) begin
                bus.wr_addr = AW'($urandom);
                bus.wr_data = DW'($urandom);
            end else begin
                bus.wr_req = 1'b0;
            end
        end
        if (m_pos == 1 && !m_wr) begin
            if (keep_rd) bus.rd_addr = AW'($urandom);
            else         bus.rd_req  = 1'b0;
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int sel = int'($urandom_range(0, 7));
        if (sel == 0) return '1;
        if (sel == 1) return '0;
        return AW'($urandom);
    endfunction

    initial begin
        reset = 1'b1;
        bus.hold = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0; bus.dq_in = '0;
        keep_wr = 1'b0; keep_rd = 1'b0;
        m_pos = 0; m_wr = 1'b0; m_last_wr = 1'b0; m_valid = 1'b0;
        m_addr = '0; m_dout = '0; m_rdata = '0;
        step(); step();
        reset = 1'b0;
        step();

        // single write
        bus.wr_req = 1'b1; bus.wr_addr = 16'h1234; bus.wr_data = 8'hA5;
        step();
        check_eq("sw_ack",  32'(bus.wr_ack), 32'd1);
        check_eq("sw_addr", 32'(bus.addr),   32'h1234);
        check_eq("sw_dq",   32'(bus.dq_out), 32'hA5);
        step();
        check_eq("sw_wr_n", 32'(bus.wr_n),   32'd0);
        step();
        check_eq("sw_idle", 32'(bus.ce_n),   32'd1);

        // single read: request sampled at edge k
        bus.dq_in = 8'h3C; bus.rd_req = 1'b1; bus.rd_addr = 16'hFFFF;
        step();
        check_eq("sr_ack",   32'(bus.rd_ack),   32'd1);
        check_eq("sr_addr",  32'(bus.addr),     32'hFFFF);
        step();
        step();
        check_eq("sr_valid", 32'(bus.rd_valid), 32'd1);
        check_eq("sr_data",  32'(bus.rd_data),  32'h3C);

        // contention from reset: tie goes to write, then alternates
        reset = 1'b1; keep_wr = 1'b1; keep_rd = 1'b1;
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        step();
        reset = 1'b0;
        step();
        check_eq("ct_first_w", 32'(bus.wr_ack), 32'd1);
        step(); step();
        check_eq("ct_then_r",  32'(bus.rd_ack), 32'd1);
        step(); step();
        check_eq("ct_then_w",  32'(bus.wr_ack), 32'd1);
        repeat (6) step();
        keep_wr = 1'b0; keep_rd = 1'b0;
        repeat (6) step();

        // hold raised during RD1
        bus.rd_req = 1'b1; bus.rd_addr = 16'h00F0;
        begin
            int n = 0;
            step();
            while (!(m_pos == 1 && !m_wr) && n < 10) begin step(); n++; end
            check_eq("hold_rd_grant_to", 32'(n < 10), 32'd1);
        end
        bus.hold = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 16'h0F0F; bus.wr_data = 8'h5A;
        step();
        step();
        check_eq("hold_rd_valid", 32'(bus.rd_valid), 32'd1);
        repeat (3) step();
        check_eq("hold_idle", 32'(bus.busy), 32'd0);
        bus.hold = 1'b0;
        step();
        check_eq("hold_release_ack", 32'(bus.wr_ack), 32'd1);
        repeat (3) step();

        // reset during WR2
        bus.wr_req = 1'b1; bus.wr_addr = 16'hBEEF; bus.wr_data = 8'h77;
        step();
        step();
        check_eq("rst_in_wr2", 32'(bus.wr_n), 32'd0);
        reset = 1'b1;
        step();
        check_eq("rst_wr_n",  32'(bus.wr_n),  32'd1);
        check_eq("rst_ce_n",  32'(bus.ce_n),  32'd1);
        check_eq("rst_dq_oe", 32'(bus.dq_oe), 32'd0);
        check_eq("rst_busy",  32'(bus.busy),  32'd0);
        reset = 1'b0;
        repeat (3) step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 149) == 0);
            bus.hold = ($urandom_range(0, 9) == 0);
            bus.dq_in = DW'($urandom);
            keep_wr  = 1'($urandom);
            keep_rd  = 1'($urandom);
            if (!bus.wr_req && $urandom_range(0, 2) == 0) begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = rand_addr();
                bus.wr_data = DW'($urandom);
            end
            if (!bus.rd_req && $urandom_range(0, 2) == 0) begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = rand_addr();
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
